// File: rtl/lhr_spec_fwd.sv
// Speculative local-history forwarding for the local-history direction predictor.
// Tracks in-flight branch histories in D/E/M, forwards the youngest match to F, repairs in E, commits from M.
module lhr_spec_fwd #(
   parameter int m = 6,
   parameter int k = 10,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         StallD,
   input  logic         StallE,
   input  logic         StallM,
   input  logic         StallW,
   input  logic         FlushD,
   input  logic         FlushE,
   input  logic         FlushM,
   input  logic         FlushW,
   input  logic         BranchF,
   input  logic [m-1:0] IndexLHRF,
   input  logic [k-1:0] LHRArrayF,
   input  logic [1:0]   BPDirF,
   input  logic         BranchE,
   input  logic         PCSrcE,
   output logic [k-1:0] LHRF,
   output logic         FwdHitF,
   output logic         LHRRepairE,
   output logic         LHRWrEnM,
   output logic [m-1:0] LHRWrIdxM,
   output logic [k-1:0] LHRWrDataM,
   output logic [C-1:0] FwdHitCnt
);

   logic         vd_q, vd_d, pd_q, pd_d;
   logic [m-1:0] idxd_q, idxd_d;
   logic [k-1:0] hd_q, hd_d;
   logic         ve_q, ve_d, pe_q, pe_d;
   logic [m-1:0] idxe_q, idxe_d;
   logic [k-1:0] he_q, he_d;
   logic         vm_q, vm_d, pm_q, pm_d;
   logic [m-1:0] idxm_q, idxm_d;
   logic [k-1:0] hm_q, hm_d;
   logic [C-1:0] cnt_q, cnt_d;

   logic         match_d, match_e, match_m;
   logic [k-1:0] hc_e, hnew_f;

   always_comb begin
      LHRRepairE = ve_q & BranchE & (PCSrcE != pe_q);
      hc_e       = LHRRepairE ? {PCSrcE, he_q[k-2:0]} : he_q;

      match_d = vd_q & (idxd_q == IndexLHRF);
      match_e = ve_q & (idxe_q == IndexLHRF);
      match_m = vm_q & (idxm_q == IndexLHRF);
      FwdHitF = match_d | match_e | match_m;

      // Youngest in-flight entry wins; E forwards its repaired history.
      if (match_d)      LHRF = hd_q;
      else if (match_e) LHRF = hc_e;
      else if (match_m) LHRF = hm_q;
      else              LHRF = LHRArrayF;

      hnew_f = {BPDirF[1], LHRF[k-1:1]};

      LHRWrEnM   = vm_q & ~StallW & ~FlushW;
      LHRWrIdxM  = idxm_q;
      LHRWrDataM = hm_q;
      FwdHitCnt  = cnt_q;
   end

   always_comb begin
      {vd_d, idxd_d, hd_d, pd_d} = {vd_q, idxd_q, hd_q, pd_q};
      {ve_d, idxe_d, he_d, pe_d} = {ve_q, idxe_q, he_q, pe_q};
      {vm_d, idxm_d, hm_d, pm_d} = {vm_q, idxm_q, hm_q, pm_q};
      cnt_d = cnt_q;

      if (FlushD)      vd_d = 1'b0;
      else if (!StallD) {vd_d, idxd_d, hd_d, pd_d} = {BranchF, IndexLHRF, hnew_f, BPDirF[1]};

      if (FlushE)      ve_d = 1'b0;
      else if (!StallE) {ve_d, idxe_d, he_d, pe_d} = {vd_q, idxd_q, hd_q, pd_q};

      if (FlushM)      vm_d = 1'b0;
      else if (!StallM) {vm_d, idxm_d, hm_d, pm_d} = {ve_q, idxe_q, hc_e, PCSrcE};

      if (FwdHitF && BranchF && (cnt_q != {C{1'b1}}))
         cnt_d = cnt_q + C'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {vd_q, idxd_q, hd_q, pd_q} <= '0;
         {ve_q, idxe_q, he_q, pe_q} <= '0;
         {vm_q, idxm_q, hm_q, pm_q} <= '0;
         cnt_q <= '0;
      end else begin
         {vd_q, idxd_q, hd_q, pd_q} <= {vd_d, idxd_d, hd_d, pd_d};
         {ve_q, idxe_q, he_q, pe_q} <= {ve_d, idxe_d, he_d, pe_d};
         {vm_q, idxm_q, hm_q, pm_q} <= {vm_d, idxm_d, hm_d, pm_d};
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lhr_spec_fwd.sv
// Scoreboard bench for lhr_spec_fwd: expectations are queued when stimulus is driven and
// compared at the falling edge; a reference pipeline model runs alongside directed cases.
module tb_lhr_spec_fwd;

   logic       clk, reset;
   logic       StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW;
   logic       BranchF, BranchE, PCSrcE;
   logic [5:0] IndexLHRF;
   logic [9:0] LHRArrayF;
   logic [1:0] BPDirF;
   logic [9:0] LHRF, LHRWrDataM, LHRF2, LHRWrDataM2;
   logic       FwdHitF, LHRRepairE, LHRWrEnM, FwdHitF2, LHRRepairE2, LHRWrEnM2;
   logic [5:0] LHRWrIdxM, LHRWrIdxM2;
   logic [15:0] FwdHitCnt;
   logic [1:0]  FwdHitCnt2;

   lhr_spec_fwd dut (
      .clk(clk), .reset(reset), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .BranchF(BranchF), .IndexLHRF(IndexLHRF), .LHRArrayF(LHRArrayF), .BPDirF(BPDirF),
      .BranchE(BranchE), .PCSrcE(PCSrcE), .LHRF(LHRF), .FwdHitF(FwdHitF), .LHRRepairE(LHRRepairE),
      .LHRWrEnM(LHRWrEnM), .LHRWrIdxM(LHRWrIdxM), .LHRWrDataM(LHRWrDataM), .FwdHitCnt(FwdHitCnt));

   lhr_spec_fwd #(.C(2)) dut_c2 (
      .clk(clk), .reset(reset), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .BranchF(BranchF), .IndexLHRF(IndexLHRF), .LHRArrayF(LHRArrayF), .BPDirF(BPDirF),
      .BranchE(BranchE), .PCSrcE(PCSrcE), .LHRF(LHRF2), .FwdHitF(FwdHitF2), .LHRRepairE(LHRRepairE2),
      .LHRWrEnM(LHRWrEnM2), .LHRWrIdxM(LHRWrIdxM2), .LHRWrDataM(LHRWrDataM2), .FwdHitCnt(FwdHitCnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      bit       v;
      bit [5:0] idx;
      bit [9:0] h;
      bit       p;
   } ent_t;
   ent_t md, me, mm;
   int   mcnt, mcnt2;
   bit [9:0] m_lhrf, m_hce;
   bit       m_hit, m_rep, m_wren;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc_n, obs, expv);
      end
   endtask

   function automatic logic [31:0] observe(input string tag);
      case (tag)
         "LHRF":       return 32'(LHRF);
         "FwdHitF":    return 32'(FwdHitF);
         "LHRRepairE": return 32'(LHRRepairE);
         "LHRWrEnM":   return 32'(LHRWrEnM);
         "LHRWrIdxM":  return 32'(LHRWrIdxM);
         "LHRWrDataM": return 32'(LHRWrDataM);
         "FwdHitCnt":  return 32'(FwdHitCnt);
         "FwdHitCnt2": return 32'(FwdHitCnt2);
         default:      return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic push(input string tag, input logic [31:0] v);
      sb_q.push_back('{tag, v});
   endtask

   task automatic drain();
      int n;
      n = sb_q.size();
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.tag, observe(e.tag), e.val);
      end
      $display("cyc=%0d checks=%0d LHRF=%h hit=%b wr=%b/%0d/%h cnt=%0d", cyc_n, n, LHRF, FwdHitF,
               LHRWrEnM, LHRWrIdxM, LHRWrDataM, FwdHitCnt);
   endtask

   task automatic model_clear();
      md = '{0, 0, 0, 0}; me = '{0, 0, 0, 0}; mm = '{0, 0, 0, 0};
      mcnt = 0; mcnt2 = 0;
   endtask

   task automatic model_comb();
      m_rep  = me.v && BranchE && (PCSrcE != me.p);
      m_hce  = m_rep ? {PCSrcE, me.h[8:0]} : me.h;
      m_hit  = 1'b1;
      if (md.v && md.idx == IndexLHRF)      m_lhrf = md.h;
      else if (me.v && me.idx == IndexLHRF) m_lhrf = m_hce;
      else if (mm.v && mm.idx == IndexLHRF) m_lhrf = mm.h;
      else begin
         m_lhrf = LHRArrayF;
         m_hit  = 1'b0;
      end
      m_wren = mm.v && !StallW && !FlushW;
   endtask

   task automatic model_push();
      model_comb();
      push("LHRF", 32'(m_lhrf));
      push("FwdHitF", 32'(m_hit));
      push("LHRRepairE", 32'(m_rep));
      push("LHRWrEnM", 32'(m_wren));
      if (m_wren) begin
         push("LHRWrIdxM", 32'(mm.idx));
         push("LHRWrDataM", 32'(mm.h));
      end
      push("FwdHitCnt", 32'(mcnt));
      push("FwdHitCnt2", 32'(mcnt2));
   endtask

   task automatic model_seq();
      ent_t nd, ne, nm;
      model_comb();
      if (reset) begin
         model_clear();
         return;
      end
      nd = md; ne = me; nm = mm;
      if (FlushD) nd.v = 0;
      else if (!StallD) nd = '{BranchF, IndexLHRF, {BPDirF[1], m_lhrf[9:1]}, BPDirF[1]};
      if (FlushE) ne.v = 0;
      else if (!StallE) ne = md;
      if (FlushM) nm.v = 0;
      else if (!StallM) nm = '{me.v, me.idx, m_hce, PCSrcE};
      if (m_hit && BranchF) begin
         if (mcnt < 65535) mcnt++;
         if (mcnt2 < 3) mcnt2++;
      end
      md = nd; me = ne; mm = nm;
   endtask

   task automatic tick();
      model_push();
      @(negedge clk);
      drain();
      @(posedge clk);
      model_seq();
      cyc_n++;
      #1;
   endtask

   task automatic idle_inputs();
      {StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW} = '0;
      BranchF = 0; BranchE = 0; PCSrcE = 0; BPDirF = 0; IndexLHRF = 0; LHRArrayF = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      model_clear();
      reset = 1'b1;
      LHRArrayF = 10'h0AB;
      #1;
      push("LHRWrEnM", 0); push("FwdHitF", 0); push("LHRF", 32'h0AB); push("FwdHitCnt", 0);
      drain();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle: committed history passes straight through.
      IndexLHRF = 5; LHRArrayF = 10'h155;
      push("LHRF", 32'h155); push("FwdHitF", 0); push("LHRWrEnM", 0);
      tick();

      // Back-to-back branches on slot 5.
      BranchF = 1; BPDirF = 2'b10; LHRArrayF = 0;
      push("LHRF", 0);
      tick();
      BPDirF = 2'b11;
      push("LHRF", 32'h200); push("FwdHitF", 1);
      tick();
      // Hold D, bubble E: D=0x300, M=0x200.
      BranchF = 0; StallD = 1; FlushE = 1;
      tick();
      StallD = 0; FlushE = 0; StallE = 1; StallM = 1; FlushD = 0;
      push("LHRF", 32'h300); push("FwdHitF", 1);
      push("LHRWrEnM", 1); push("LHRWrIdxM", 5); push("LHRWrDataM", 32'h200);
      tick();

      // Repair in E.
      idle_inputs();
      do_reset();
      BranchF = 1; IndexLHRF = 5; BPDirF = 2'b10; LHRArrayF = 10'h3FF;
      tick();
      BranchF = 0;
      tick();
      BranchE = 1; PCSrcE = 0;
      push("LHRRepairE", 1); push("LHRF", 32'h1FF);
      tick();
      BranchE = 0;
      StallM = 1; StallW = 1;
      for (int i = 0; i < 3; i++) begin
         push("LHRWrEnM", 0);
         tick();
      end
      StallW = 0; FlushW = 1;
      push("LHRWrEnM", 0);
      tick();
      StallM = 0; FlushW = 0;
      push("LHRWrEnM", 1); push("LHRWrIdxM", 5); push("LHRWrDataM", 32'h1FF);
      tick();
      push("LHRWrEnM", 0);
      tick();

      // Saturating counter on the narrow instance.
      idle_inputs();
      do_reset();
      BranchF = 1; IndexLHRF = 7; BPDirF = 2'b01;
      for (int j = 0; j <= 6; j++) begin
         push("FwdHitCnt2", (j < 2) ? 0 : ((j - 1 > 3) ? 3 : j - 1));
         tick();
      end
      // Asynchronous reset mid-cycle clears everything at once.
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      #1;
      push("FwdHitCnt2", 0); push("FwdHitCnt", 0); push("FwdHitF", 0); push("LHRWrEnM", 0);
      drain();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random traffic against the reference model.
      for (int r = 0; r < 400; r++) begin
         StallD = ($urandom_range(0, 3) == 0);
         StallE = ($urandom_range(0, 3) == 0);
         StallM = ($urandom_range(0, 3) == 0);
         StallW = ($urandom_range(0, 4) == 0);
         FlushD = ($urandom_range(0, 7) == 0);
         FlushE = ($urandom_range(0, 7) == 0);
         FlushM = ($urandom_range(0, 9) == 0);
         FlushW = ($urandom_range(0, 9) == 0);
         BranchF   = $urandom_range(0, 1);
         IndexLHRF = 6'($urandom_range(0, 3));
         LHRArrayF = 10'($urandom);
         BPDirF    = 2'($urandom);
         BranchE   = $urandom_range(0, 1);
         PCSrcE    = $urandom_range(0, 1);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
